// File: rtl/dmem_pkg.sv
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants for the data-memory arbiter and its clients.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package dmem_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam int PORT_CPU  = 0;
    localparam int PORT_HOST = 1;

    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;

    // CPU side derives its per-port write enable from the instruction opcode.
    function automatic logic op_is_store(input logic [5:0] i_op);
        return (i_op == OP_SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module      : rr_arb2
// Description : Combinational 2-way round-robin selector with lock override.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rr_arb2
    import dmem_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_prio,
    input  logic       i_lock,
    output logic [1:0] o_gnt,
    output logic       o_forced
);

    always_comb begin
        o_gnt    = 2'b00;
        o_forced = 1'b0;
        case (i_req)
            2'b01: o_gnt = 2'b01;
            2'b10: o_gnt = 2'b10;
            2'b11: begin
                // Lock only counts as forcing when it actually overrode a contender.
                if (i_lock) begin
                    o_gnt[PORT_HOST] = 1'b1;
                    o_forced         = 1'b1;
                end else if (i_prio) begin
                    o_gnt = 2'b10;
                end else begin
                    o_gnt = 2'b01;
                end
            end
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module      : dmem_arbiter
// Description : CPU/host arbiter for the single-port data memory, 1-cycle loads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [1:0]        we,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              host_lock,
    output logic [1:0]        gnt,
    output logic [1:0]        rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic       r_prio;
    logic       r_resp_vld;
    logic       r_resp_port;
    logic [1:0] w_arb_gnt;
    logic       w_forced;
    logic       w_sel;

    rr_arb2 u_rr_arb2 (
        .i_req    (req),
        .i_prio   (r_prio),
        .i_lock   (host_lock),
        .o_gnt    (w_arb_gnt),
        .o_forced (w_forced)
    );

    assign gnt   = rst ? 2'b00 : w_arb_gnt;
    assign w_sel = gnt[PORT_HOST];

    // Port 0 values are presented whenever port 1 is not granted, including idle.
    assign mem_en    = |gnt;
    assign mem_we    = mem_en & (w_sel ? we[PORT_HOST] : we[PORT_CPU]);
    assign mem_addr  = w_sel ? addr1  : addr0;
    assign mem_wdata = w_sel ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio      <= 1'b0;
            r_resp_vld  <= 1'b0;
            r_resp_port <= 1'b0;
        end else begin
            if (mem_en && !w_forced) begin
                r_prio <= ~w_sel;
            end
            r_resp_vld  <= mem_en & ~mem_we;
            r_resp_port <= w_sel;
        end
    end

    // A response in flight when reset arrives is suppressed immediately.
    assign rvalid = (r_resp_vld && !rst) ? (r_resp_port ? 2'b10 : 2'b01) : 2'b00;
    assign rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [1:0] we;
    logic [7:0] addr0, addr1, wdata0, wdata1;
    logic       host_lock;
    logic [1:0] gnt, rvalid;
    logic [7:0] rdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0] mem [256];

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .host_lock (host_lock),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: write at the grant edge, registered read one cycle later.
    always @(posedge clk) begin
        if (rst) begin
            mem[0] <= 8'hEC;
            mem[1] <= 8'h0A;
            mem[2] <= 8'h02;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 2'b11; we = 2'b00; addr0 = 8'd0; addr1 = 8'd1;
        wdata0 = 8'h00; wdata1 = 8'h00; host_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt[%0d]: got %b want 00", i, gnt); end
            n_cmp++; if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_mem_en[%0d]: got %b want 0", i, mem_en); end
            n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid[%0d]: got %b want 00", i, rvalid); end
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rst_first_gnt: got %b want 01", gnt); end
        tick();
        req = 2'b00;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL rst_first_rvalid: got %b want 01", rvalid); end
        n_cmp++; if (rdata !== 8'hEC) begin n_fail++; $display("FAIL rst_first_rdata: got %h want EC", rdata); end
        tick();
    endtask

    task automatic test_single_load();
        req = 2'b01; we = 2'b00; addr0 = 8'd0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL sl_gnt: got %b want 01", gnt); end
        n_cmp++; if (mem_en !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL sl_mem_en_we: got %b%b want 10", mem_en, mem_we); end
        n_cmp++; if (mem_addr !== 8'd0) begin n_fail++; $display("FAIL sl_mem_addr: got %h want 00", mem_addr); end
        tick();
        req = 2'b00;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b01) begin n_fail++; $display("FAIL sl_rvalid: got %b want 01", rvalid); end
        n_cmp++; if (rdata !== 8'hEC) begin n_fail++; $display("FAIL sl_rdata: got %h want EC", rdata); end
        tick();
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt [4];
        logic [1:0] exp_rv  [5];
        logic [7:0] exp_rd  [5];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_rv  = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10};
        exp_rd  = '{8'h00, 8'h0A, 8'h02, 8'h0A, 8'h02};
        // Single host load leaves the pointer preferring port 0.
        req = 2'b10; we = 2'b00; addr1 = 8'd2;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL ct_pre_gnt: got %b want 10", gnt); end
        tick();
        req = 2'b00;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b10 || rdata !== 8'h02) begin n_fail++; $display("FAIL ct_pre_resp: got %b/%h want 10/02", rvalid, rdata); end
        tick();
        req = 2'b11; addr0 = 8'd1; addr1 = 8'd2;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) req = 2'b00;
            @(negedge clk);
            if (i < 4) begin
                n_cmp++; if (gnt !== exp_gnt[i]) begin n_fail++; $display("FAIL ct_gnt[%0d]: got %b want %b", i, gnt, exp_gnt[i]); end
            end
            n_cmp++; if (rvalid !== exp_rv[i]) begin n_fail++; $display("FAIL ct_rvalid[%0d]: got %b want %b", i, rvalid, exp_rv[i]); end
            if (i > 0) begin
                n_cmp++; if (rdata !== exp_rd[i]) begin n_fail++; $display("FAIL ct_rdata[%0d]: got %h want %h", i, rdata, exp_rd[i]); end
            end
            tick();
        end
    endtask

    task automatic test_raw();
        req = 2'b10; we = 2'b10; addr1 = 8'd2; wdata1 = 8'h55;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL raw_wr_gnt: got %b want 10", gnt); end
        n_cmp++; if (mem_we !== 1'b1 || mem_wdata !== 8'h55 || mem_addr !== 8'd2) begin n_fail++; $display("FAIL raw_wr_bus: got we=%b d=%h a=%h want 1/55/02", mem_we, mem_wdata, mem_addr); end
        tick();
        req = 2'b01; we = 2'b00; addr0 = 8'd2;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL raw_rd_gnt: got %b want 01", gnt); end
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL raw_store_rvalid: got %b want 00", rvalid); end
        tick();
        req = 2'b00;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b01 || rdata !== 8'h55) begin n_fail++; $display("FAIL raw_rd_resp: got %b/%h want 01/55", rvalid, rdata); end
        tick();
    endtask

    task automatic test_lock();
        // Pointer is 1 here; one unlocked contention returns it to 0.
        req = 2'b11; we = 2'b00; addr0 = 8'd0; addr1 = 8'd1; host_lock = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_pre_gnt: got %b want 10", gnt); end
        tick();
        host_lock = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_gnt[%0d]: got %b want 10", i, gnt); end
            tick();
        end
        host_lock = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL lk_release_gnt: got %b want 01", gnt); end
        n_cmp++; if (rvalid !== 2'b10 || rdata !== 8'h0A) begin n_fail++; $display("FAIL lk_rvalid: got %b/%h want 10/0A", rvalid, rdata); end
        tick();
        // Pointer now 1: a locked burst must not move it.
        host_lock = 1'b1;
        for (int i = 0; i < 2; i++) tick();
        host_lock = 1'b0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL lk_prio_kept: got %b want 10", gnt); end
        tick();
        req = 2'b00;
        tick();
    endtask

    task automatic test_reset_mid_load();
        req = 2'b01; we = 2'b00; addr0 = 8'd0;
        @(negedge clk);
        n_cmp++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rml_gnt: got %b want 01", gnt); end
        tick();
        rst = 1'b1; req = 2'b11;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rml_rvalid_n1: got %b want 00", rvalid); end
        n_cmp++; if (gnt !== 2'b00 || mem_en !== 1'b0) begin n_fail++; $display("FAIL rml_gnt_in_rst: got %b/%b want 00/0", gnt, mem_en); end
        tick();
        rst = 1'b0; req = 2'b00;
        @(negedge clk);
        n_cmp++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rml_rvalid_n2: got %b want 00", rvalid); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_contention();
        test_raw();
        test_lock();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
